meter_display: RTL and testbench
================================

Name: meter_display

Overview:
- Downstream display stage of the parking meter; consumes the binary seconds count produced by the meter counter.
- Converts the count to BCD with a sequential double-dabble engine and time-multiplexes the four 7-segment digits.
- Blinks the whole display when the remaining time is below a threshold.
- Replaces the combinational divide/modulo BCD path and the separate display FSM.

Parameters:
- WIDTH, 14, width of count_in.
- MAX_COUNT, 9999, saturation value for display.
- FLASH_THRESH, 200, display blinks while the displayed value is below this.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz).
- FLASH_HALF, 50000000, clk cycles per blink half-period (on, then off).

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- count_in  input  WIDTH  binary count from the meter counter.
- bcd_out  output  16  latched BCD of the displayed value, [15:12] thousands … [3:0] ones.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit enables, active low, an[0] = ones digit.
- seg  output  7  segments, active low, seg[0]=a … seg[6]=g.

Behaviour:
- Reset values:
  - an=4'b1111, seg=7'b1111111, bcd_out=0, busy=0.
  - Digit index 0, refresh and blink counters 0, blink phase ON.
  - FSM in IDLE; last_val marked invalid, so the first IDLE cycle after reset starts a conversion.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If last_val is invalid or count_in != last_val, capture the value. If count_in > MAX_COUNT, capture MAX_COUNT instead.
  - Store the raw count_in into last_val.
  - Clear the 16-bit scratch BCD register, set busy=1, go to SHIFT.
- SHIFT: exactly WIDTH cycles. Each cycle:
  - Add 3 to every scratch nibble that is >= 5.
  - Then shift {scratch, operand} left by 1.
- DONE (1 cycle):
  - bcd_out <= scratch, busy <= 0.
  - Return to IDLE.
- Latency: bcd_out is updated 1+WIDTH+1 = 16 clocks after the IDLE cycle that captures a new count.
- count_in changes during SHIFT/DONE are ignored. The next IDLE compares again and restarts if needed.
- The display shows only the last completed bcd_out, so no partially converted digits ever appear.
- Reset mid-conversion aborts immediately to the reset state.
- Refresh:
  - Counter wraps at REFRESH_DIV-1.
  - Digit index advances 0→1→2→3→0 on each wrap.
  - an drives a one-hot low on the current index.
  - seg drives the decoded nibble: standard 0–9 patterns; nibbles 10–15 drive all segments off.
- Blink:
  - Counter wraps at FLASH_HALF-1 and toggles the phase on each wrap. It is free-running and not resynchronised to count changes.
  - While the value in bcd_out is below FLASH_THRESH (compared as a binary value held alongside bcd_out) and the phase is OFF, an=4'b1111.
  - Otherwise an follows the refresh logic.
  - A value of 0 also blinks.
- an and seg are registered, giving 1 cycle of delay after the index or data changes.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked (an bit held high for that slot). Digit 0 is always shown, so 0 displays as a single "0" and 205 displays as " 205".
- Undefined: all four digits are always driven, so 205 displays as "0205".

Test Plan:
- Reset asserted mid-SHIFT while converting 1234: an=1111, seg=1111111, busy=0 asynchronously. After release, 16 clocks later bcd_out=16'h1234.
- count_in=9999 → bcd_out=16'h9999. count_in=14'h3FFF (16383) → bcd_out=16'h9999 (saturation).
- count_in 205→206 during SHIFT: bcd_out=16'h0205 first, then 16'h0206 within 32 clocks of the change. No other intermediate value appears on bcd_out.
- REFRESH_DIV=4, count 4321: an cycles 1110,1101,1011,0111 every 4 clocks. seg shows "1","2","3","4" patterns (e.g. 7'b1111001 for "1").
- FLASH_HALF=8, FLASH_THRESH=200: with count 199, an=1111 for 8 clocks of every 16. With count 200, an is never all-high for a full refresh cycle.
- LEADING_ZERO_BLANK_EN defined, count 10: only an[1:0] are ever driven low; count 0 drives only an[0] low.

Source files
------------

// File: rtl/meter_display.sv
// Parking-meter display stage: sequential double-dabble BCD conversion, 4-digit
// multiplexed active-low 7-segment drive and low-time blink. Option: LEADING_ZERO_BLANK_EN.
module meter_display #(
    parameter int WIDTH        = 14,
    parameter int MAX_COUNT    = 9999,
    parameter int FLASH_THRESH = 200,
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_HALF   = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    output logic [15:0]      bcd_out,
    output logic             busy,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_VAL      = WIDTH'(MAX_COUNT);
    localparam logic [RW-1:0]    REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0]    FLASH_LAST   = FW'(FLASH_HALF - 1);
    localparam logic [CW-1:0]    SHIFT_LAST   = CW'(WIDTH - 1);
    localparam logic [31:0]      THRESH_VAL   = 32'(FLASH_THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] last_val_r;
    logic             last_valid_r;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] conv_val_r;
    logic [WIDTH-1:0] bin_val_r;
    logic [15:0]      scratch_r;
    logic [15:0]      adjusted_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [RW-1:0]    refresh_cnt_r;
    logic [FW-1:0]    flash_cnt_r;
    logic [1:0]       digit_idx_r;
    logic             blink_on_r;
    logic             start_s;
    logic [WIDTH-1:0] cap_s;
    logic [3:0]       digit_s;
    logic             flash_s;
    logic             blank_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            else                     r[i*4 +: 4] = s[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign start_s    = (state_r == IDLE) && (!last_valid_r || (count_in != last_val_r));
    assign cap_s      = (count_in > MAX_VAL) ? MAX_VAL : count_in;
    assign adjusted_s = dabble_adjust(scratch_r);

    // Conversion FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Conversion FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start_s) state_s = SHIFT; else state_s = IDLE;
            SHIFT:   if (bit_cnt_r == SHIFT_LAST) state_s = DONE; else state_s = SHIFT;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Conversion datapath; bcd_out and its binary twin only change in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_val_r   <= '0;
            last_valid_r <= 1'b0;
            operand_r    <= '0;
            conv_val_r   <= '0;
            bin_val_r    <= '0;
            scratch_r    <= 16'd0;
            bit_cnt_r    <= '0;
            bcd_out      <= 16'd0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        operand_r    <= cap_s;
                        conv_val_r   <= cap_s;
                        last_val_r   <= count_in;
                        last_valid_r <= 1'b1;
                        scratch_r    <= 16'd0;
                        bit_cnt_r    <= '0;
                        busy         <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch_r <= {adjusted_s[14:0], operand_r[WIDTH-1]};
                    operand_r <= {operand_r[WIDTH-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                end
                DONE: begin
                    bcd_out   <= scratch_r;
                    bin_val_r <= conv_val_r;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Digit refresh and free-running blink timebases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= 2'd0;
            flash_cnt_r   <= '0;
            blink_on_r    <= 1'b1;
        end else begin
            if (refresh_cnt_r == REFRESH_LAST) begin
                refresh_cnt_r <= '0;
                digit_idx_r   <= digit_idx_r + 2'd1;
            end else begin
                refresh_cnt_r <= refresh_cnt_r + RW'(1);
            end
            if (flash_cnt_r == FLASH_LAST) begin
                flash_cnt_r <= '0;
                blink_on_r  <= ~blink_on_r;
            end else begin
                flash_cnt_r <= flash_cnt_r + FW'(1);
            end
        end
    end

    // Digit select, blanking and segment decode
    always_comb begin
        digit_s = bcd_out[3:0];
        blank_s = 1'b0;
        case (digit_idx_r)
            2'd0:    digit_s = bcd_out[3:0];
            2'd1:    digit_s = bcd_out[7:4];
            2'd2:    digit_s = bcd_out[11:8];
            2'd3:    digit_s = bcd_out[15:12];
            default: digit_s = bcd_out[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_idx_r)
            2'd1:    blank_s = (bcd_out[15:4] == 12'd0);
            2'd2:    blank_s = (bcd_out[15:8] == 8'd0);
            2'd3:    blank_s = (bcd_out[15:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        flash_s = (32'(bin_val_r) < THRESH_VAL) && !blink_on_r;
        if (flash_s || blank_s) an_s = 4'b1111;
        else                    an_s = ~(4'b0001 << digit_idx_r);
        seg_s = seg_decode(digit_s);
    end

    // Registered display drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_s;
            seg <= seg_s;
        end
    end

endmodule

// File: tb/tb_meter_display.sv
// Randomised self-checking bench for meter_display against an arithmetic timeline model.
module tb_meter_display;
    localparam int W   = 14;
    localparam int MAXC = 9999;
    localparam int THR = 200;
    localparam int RD  = 4;
    localparam int FH  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  count_in = '0;
    logic [15:0]   bcd_out;
    logic          busy;
    logic [3:0]    an;
    logic [6:0]    seg;

    int checks = 0;
    int errors = 0;

    // model state: edge number since reset release and conversion timeline
    int n, last, idle_at, done_at, pend, disp, prev_disp;
    bit valid, busy_m;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    meter_display #(.WIDTH(W), .MAX_COUNT(MAXC), .FLASH_THRESH(THR),
                    .REFRESH_DIV(RD), .FLASH_HALF(FH)) dut (
        .clk(clk), .reset(reset), .count_in(count_in),
        .bcd_out(bcd_out), .busy(busy), .an(an), .seg(seg));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic int pow10(input int i);
        case (i)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    task automatic model_reset();
        n = 0; valid = 1'b0; last = 0; idle_at = 1; done_at = -1;
        pend = 0; disp = 0; prev_disp = 0; busy_m = 1'b0;
    endtask

    task automatic model_edge(input int cin);
        n++;
        prev_disp = disp;
        if (n == done_at) begin
            disp = pend;
            busy_m = 1'b0;
        end
        if (n >= idle_at && (!valid || cin != last)) begin
            pend = (cin > MAXC) ? MAXC : cin;
            last = cin;
            valid = 1'b1;
            done_at = n + W + 1;
            idle_at = n + W + 2;
            busy_m = 1'b1;
        end
    endtask

    // entered and left at a falling edge; samples 1 time unit after the rising edge
    task automatic cycle(input int cin);
        int m, idx, digit;
        bit on, blank;
        logic [3:0] exp_an;
        count_in = W'(cin);
        @(posedge clk);
        model_edge(cin);
        m = n - 1;
        idx = (m / RD) % 4;
        on = ((m / FH) % 2) == 0;
        digit = (prev_disp / pow10(idx)) % 10;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx > 0) && (prev_disp < pow10(idx));
`endif
        if ((prev_disp < THR && !on) || blank) exp_an = 4'b1111;
        else                                    exp_an = ~(4'b0001 << idx);
        #1;
        check_eq("bcd_out", 32'(bcd_out), 32'(to_bcd(disp)));
        check_eq("busy", 32'(busy), 32'(busy_m));
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg", 32'(seg), 32'(seg_tab[digit]));
        @(negedge clk);
    endtask

    task automatic hold(input int cin, input int len);
        for (int i = 0; i < len; i++) cycle(cin);
    endtask

    initial begin
        int v, len;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_an", 32'(an), 32'h0000_000F);
        check_eq("rst_seg", 32'(seg), 32'h0000_007F);
        check_eq("rst_bcd", 32'(bcd_out), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // reset in the middle of converting 1234
        hold(1234, 6);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_an", 32'(an), 32'h0000_000F);
        check_eq("midrst_seg", 32'(seg), 32'h0000_007F);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        hold(1234, 40);

        hold(9999, 40);
        hold(16383, 40);
        hold(205, 3);
        hold(206, 40);
        hold(4321, 40);
        hold(199, 40);
        hold(200, 40);
        hold(10, 40);
        hold(0, 40);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 300));
            else                           v = int'($urandom_range(0, 16383));
            len = int'($urandom_range(1, 40));
            hold(v, len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
